// File: rtl/jpeg_block_sched.sv
// Block-order pixel scheduler: walks a frame in 8x8 blocks, reads each pixel from
// memory and forwards it, tagged with its block position, to the JPEG encoder.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; config is latched when start arrives
// FETCH    | issuing reads and draining the 2-entry buffer to the encoder
// WAIT_END | all pixels written; waiting for enc_end, or timing out
module jpeg_block_sched #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_base,
  input  logic [15:0] cfg_stride,
  input  logic [7:0]  cfg_blk_w,
  input  logic [7:0]  cfg_blk_h,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        enc_req,
  output logic [9:0]  enc_add,
  output logic [31:0] enc_wdata,
  input  logic        enc_gnt,
  input  logic        enc_end
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] base_q;
  logic [15:0] stride_q;
  logic [7:0]  blk_w_q, blk_h_q;

  logic [2:0]  col_q, row_q;
  logic [7:0]  bx_q, by_q;
  logic        issue_done_q;
  logic [TW-1:0] wait_cnt_q;
  logic        done_q, err_q;
  logic        done_d, err_d;

  // Sideband layout: {final pixel, last block, row, col}
  logic [7:0]  out_sb [2];
  logic        out_wr_q, out_rd_q;
  logic [1:0]  out_cnt_q;

  logic [31:0] buf_data [2];
  logic [7:0]  buf_sb [2];
  logic        buf_wr_q, buf_rd_q;
  logic [1:0]  buf_cnt_q;

  logic        cfg_bad;
  logic        start_ok;
  logic        issue, push, pop;
  logic        last_blk;
  logic        last_pix;
  logic        timeout_hit;
  logic [7:0]  issue_sb;
  logic [7:0]  head_sb;
  logic [31:0] line_off, pix_off, addr_c;
  logic [2:0]  inflight;

  assign cfg_bad     = (cfg_blk_w == 8'd0) || (cfg_blk_h == 8'd0);
  assign start_ok    = (state_q == IDLE) && start;
  assign last_blk    = (bx_q == blk_w_q - 8'd1) && (by_q == blk_h_q - 8'd1);
  assign last_pix    = last_blk && (row_q == 3'd7) && (col_q == 3'd7);
  assign issue_sb    = {last_pix, last_blk, row_q, col_q};
  assign head_sb     = buf_sb[buf_rd_q];
  assign timeout_hit = (wait_cnt_q == TW'(TIMEOUT - 1));
  assign inflight    = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};

  assign line_off = 32'({by_q, row_q}) * 32'(stride_q);
  assign pix_off  = 32'({bx_q, col_q, 2'b00});
  assign addr_c   = base_q + line_off + pix_off;

  assign issue = mem_req && mem_gnt;
  // A return with nothing outstanding is a leftover from before a reset.
  assign push  = mem_rvalid && (out_cnt_q != 2'd0);
  assign pop   = enc_req && enc_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start && !cfg_bad) state_d = FETCH;
      FETCH:    if (pop && head_sb[7]) state_d = WAIT_END;
      WAIT_END: if (enc_end || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_req   = (state_q == FETCH) && !issue_done_q && (inflight < 3'd2);
    enc_req   = (buf_cnt_q != 2'd0);
    mem_addr  = mem_req ? addr_c : 32'd0;
    enc_add   = enc_req ? {1'b0, head_sb[6], head_sb[5:0], 2'b00} : 10'd0;
    enc_wdata = enc_req ? buf_data[buf_rd_q] : 32'd0;
    done_d    = (state_q == WAIT_END) && enc_end;
    err_d     = (start_ok && cfg_bad) ||
                ((state_q == WAIT_END) && !enc_end && timeout_hit);
    done      = done_q;
    err       = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= 32'd0;
      stride_q     <= 16'd0;
      blk_w_q      <= 8'd0;
      blk_h_q      <= 8'd0;
      col_q        <= 3'd0;
      row_q        <= 3'd0;
      bx_q         <= 8'd0;
      by_q         <= 8'd0;
      issue_done_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      if (start_ok) begin
        base_q       <= cfg_base;
        stride_q     <= cfg_stride;
        blk_w_q      <= cfg_blk_w;
        blk_h_q      <= cfg_blk_h;
        col_q        <= 3'd0;
        row_q        <= 3'd0;
        bx_q         <= 8'd0;
        by_q         <= 8'd0;
        issue_done_q <= 1'b0;
      end else if (issue) begin
        if (col_q != 3'd7) begin
          col_q <= col_q + 3'd1;
        end else begin
          col_q <= 3'd0;
          if (row_q != 3'd7) begin
            row_q <= row_q + 3'd1;
          end else begin
            row_q <= 3'd0;
            if (bx_q != blk_w_q - 8'd1) begin
              bx_q <= bx_q + 8'd1;
            end else begin
              bx_q <= 8'd0;
              if (by_q != blk_h_q - 8'd1) by_q <= by_q + 8'd1;
              else issue_done_q <= 1'b1;
            end
          end
        end
      end

      if (state_q == WAIT_END) wait_cnt_q <= wait_cnt_q + TW'(1);
      else wait_cnt_q <= '0;
    end
  end

  // Outstanding-read tags: returns are in order, so tags pair up FIFO-wise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sb[0] <= 8'd0;
      out_sb[1] <= 8'd0;
      out_wr_q  <= 1'b0;
      out_rd_q  <= 1'b0;
      out_cnt_q <= 2'd0;
    end else begin
      if (issue) begin
        out_sb[out_wr_q] <= issue_sb;
        out_wr_q         <= ~out_wr_q;
      end
      if (push) out_rd_q <= ~out_rd_q;
      out_cnt_q <= out_cnt_q + 2'(issue) - 2'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data[0] <= 32'd0;
      buf_data[1] <= 32'd0;
      buf_sb[0]   <= 8'd0;
      buf_sb[1]   <= 8'd0;
      buf_wr_q    <= 1'b0;
      buf_rd_q    <= 1'b0;
      buf_cnt_q   <= 2'd0;
    end else begin
      if (push) begin
        buf_data[buf_wr_q] <= mem_rdata;
        buf_sb[buf_wr_q]   <= out_sb[out_rd_q];
        buf_wr_q           <= ~buf_wr_q;
      end
      if (pop) buf_rd_q <= ~buf_rd_q;
      buf_cnt_q <= buf_cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_jpeg_block_sched.sv
// Directed bench for jpeg_block_sched: memory and encoder models driven cycle by
// cycle from one initial block, with immediate assertions at every check point.
module tb_jpeg_block_sched;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [7:0]  cfg_blk_w, cfg_blk_h;
  logic        busy, done, err;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        enc_req, enc_gnt, enc_end;
  logic [9:0]  enc_add;
  logic [31:0] enc_wdata;

  always #5 clk = ~clk;

  jpeg_block_sched #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_blk_w(cfg_blk_w), .cfg_blk_h(cfg_blk_h),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .enc_req(enc_req), .enc_add(enc_add), .enc_wdata(enc_wdata),
    .enc_gnt(enc_gnt), .enc_end(enc_end)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_base;
  int m_stride, m_w, m_h;
  int cyc = 0;
  int granted, written, bit8_cnt;
  int mgnt_pct, egnt_pct, lat_min, lat_max;
  logic [31:0] pend_addr[$];
  int          pend_ready[$];
  logic [31:0] gaddr [0:1023];
  logic        prev_mreq, prev_mgnt, prev_ereq, prev_egnt;
  logic [31:0] prev_maddr, prev_ewd, prev_eadd;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    int blk, pix, bx, by, row, col;
    blk = k / 64; pix = k % 64;
    bx = blk % m_w; by = blk / m_w;
    row = pix / 8; col = pix % 8;
    return m_base + 32'((by * 8 + row) * m_stride) + 32'((bx * 8 + col) * 4);
  endfunction

  function automatic logic [31:0] exp_add(input int k);
    logic [31:0] r;
    int blk, pix, bx, by;
    blk = k / 64; pix = k % 64;
    bx = blk % m_w; by = blk / m_w;
    r = 32'd0;
    r[8] = (bx == m_w - 1) && (by == m_h - 1);
    r[7:2] = pix[5:0];
    return r;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] a);
    return a * 32'h9E37_79B1;
  endfunction

  task automatic clear_prev();
    prev_mreq = 1'b0; prev_mgnt = 1'b0; prev_ereq = 1'b0; prev_egnt = 1'b0;
    prev_maddr = 32'd0; prev_ewd = 32'd0; prev_eadd = 32'd0;
  endtask

  // One cycle: sample at negedge, check, then drive memory/encoder responses.
  task automatic step();
    int lat;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    enc_end = 1'b0;
    if (prev_mreq && !prev_mgnt) begin
      chk1("mem_req_hold", mem_req, 1'b1);
      chk32("mem_addr_hold", mem_addr, prev_maddr);
    end
    if (prev_ereq && !prev_egnt) begin
      chk1("enc_req_hold", enc_req, 1'b1);
      chk32("enc_wdata_hold", enc_wdata, prev_ewd);
      chk32("enc_add_hold", 32'(enc_add), prev_eadd);
    end
    if (busy) chk1("inflight_le2", (granted - written) <= 2, 1'b1);
    mem_gnt = 1'b0;
    if (mem_req && int'($urandom_range(99)) < mgnt_pct) begin
      chk32("mem_addr", mem_addr, exp_addr(granted));
      if (granted < 1024) gaddr[granted] = mem_addr;
      lat = int'($urandom_range(lat_max, lat_min));
      pend_addr.push_back(mem_addr);
      pend_ready.push_back(cyc + lat);
      granted++;
      mem_gnt = 1'b1;
    end
    mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    if (pend_addr.size() > 0 && pend_ready[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = mix(pend_addr.pop_front());
      void'(pend_ready.pop_front());
    end
    enc_gnt = 1'b0;
    if (enc_req && int'($urandom_range(99)) < egnt_pct) begin
      chk32("enc_wdata", enc_wdata, mix(exp_addr(written)));
      chk32("enc_add", 32'(enc_add), exp_add(written));
      if (enc_add[8]) bit8_cnt++;
      written++;
      enc_gnt = 1'b1;
    end
    prev_mreq = mem_req; prev_mgnt = mem_gnt; prev_maddr = mem_addr;
    prev_ereq = enc_req; prev_egnt = enc_gnt; prev_ewd = enc_wdata;
    prev_eadd = 32'(enc_add);
  endtask

  task automatic setup(input logic [31:0] b, input int s, input int w, input int h,
                       input int mp, input int ep, input int lmin, input int lmax);
    m_base = b; m_stride = s; m_w = w; m_h = h;
    mgnt_pct = mp; egnt_pct = ep; lat_min = lmin; lat_max = lmax;
    granted = 0; written = 0; bit8_cnt = 0;
    cfg_base = b; cfg_stride = 16'(s); cfg_blk_w = 8'(w); cfg_blk_h = 8'(h);
    start = 1'b1;
  endtask

  // Runs until the last encoder write is granted; poke >= 0 fires a stray start.
  task automatic run_frame(input logic [31:0] b, input int s, input int w, input int h,
                           input int mp, input int ep, input int lmin, input int lmax,
                           input int poke);
    int total, guard;
    bit poked;
    total = 64 * w * h;
    guard = 0;
    poked = 1'b0;
    setup(b, s, w, h, mp, ep, lmin, lmax);
    step();
    chk1("busy_after_start", busy, 1'b1);
    while (written < total && guard < 20000) begin
      if (poke >= 0 && written == poke && !poked) begin
        poked = 1'b1;
        start = 1'b1;
        cfg_base = 32'hDEAD_0000;
        cfg_blk_w = 8'd1;
        cfg_blk_h = 8'd0;
      end
      step();
      guard++;
    end
    chk32("frame_writes", 32'(written), 32'(total));
    chk32("add8_count", 32'(bit8_cnt), 32'd64);
  endtask

  task automatic finish_done();
    step();
    chk1("wait_end_busy", busy, 1'b1);
    chk1("wait_end_no_done", done, 1'b0);
    step();
    step();
    enc_end = 1'b1;
    step();
    chk1("done_pulse", done, 1'b1);
    chk1("done_idle", busy, 1'b0);
    chk1("done_no_err", err, 1'b0);
    step();
    chk1("done_once", done, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_enc_req"}, enc_req, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk32({tag, "_enc_add"}, 32'(enc_add), 32'd0);
    chk32({tag, "_enc_wdata"}, enc_wdata, 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; enc_end = 1'b0;
    cfg_base = 32'd0; cfg_stride = 16'd0; cfg_blk_w = 8'd0; cfg_blk_h = 8'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; enc_gnt = 1'b0;
    m_base = 32'd0; m_stride = 0; m_w = 1; m_h = 1;
    mgnt_pct = 100; egnt_pct = 100; lat_min = 1; lat_max = 1;
    granted = 0; written = 0; bit8_cnt = 0;
    clear_prev();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // enc_end while idle must not produce done
    enc_end = 1'b1;
    step();
    chk1("idle_enc_end", done, 1'b0);
    step();
    chk1("idle_enc_end2", done, 1'b0);

    // 1x1 frame, minimum latency, encoder always ready
    run_frame(32'h0000_1000, 32, 1, 1, 100, 100, 1, 1, -1);
    chk32("a1_first", gaddr[0], 32'h0000_1000);
    chk32("a1_col7", gaddr[7], 32'h0000_101C);
    chk32("a1_row1", gaddr[8], 32'h0000_1020);
    chk32("a1_last", gaddr[63], 32'h0000_10FC);
    finish_done();

    // 2x2 frame
    run_frame(32'h0000_2000, 64, 2, 2, 100, 100, 1, 2, -1);
    chk32("a2_blk10", gaddr[64], 32'h0000_2020);
    chk32("a2_blk01", gaddr[128], 32'h0000_2200);
    chk32("a2_last", gaddr[255], 32'h0000_23FC);
    finish_done();

    // backpressure, address wrap, stray start mid-frame
    run_frame(32'hFFFF_FC00, 128, 3, 2, 60, 30, 1, 5, 50);
    finish_done();

    // config error
    cfg_base = 32'h0000_5000; cfg_stride = 16'd32; cfg_blk_w = 8'd3; cfg_blk_h = 8'd0;
    start = 1'b1;
    step();
    chk1("cfgerr_err", err, 1'b1);
    chk1("cfgerr_busy", busy, 1'b0);
    chk1("cfgerr_mem_req", mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("cfgerr_err_once", err, 1'b0);
      chk1("cfgerr_busy_after", busy, 1'b0);
      chk1("cfgerr_no_req", mem_req, 1'b0);
    end

    // timeout with enc_end withheld
    run_frame(32'h0000_3000, 32, 1, 1, 100, 100, 1, 1, -1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk1("to_busy", busy, 1'b1);
      chk1("to_no_err", err, 1'b0);
    end
    step();
    chk1("to_err", err, 1'b1);
    chk1("to_idle", busy, 1'b0);
    chk1("to_no_done", done, 1'b0);
    step();
    chk1("to_err_once", err, 1'b0);
    enc_end = 1'b1;
    step();
    chk1("to_late_end", done, 1'b0);
    step();
    chk1("to_late_end2", done, 1'b0);

    // mid-frame reset around pixel 100 of a 2x1 frame
    setup(32'h0000_4000, 64, 2, 1, 100, 100, 3, 3);
    guard = 0;
    while (!(granted >= 100 && pend_addr.size() == 2) && guard < 5000) begin
      step();
      guard++;
    end
    chk1("rst_point_reached", (granted >= 100) && (pend_addr.size() == 2), 1'b1);
    rst = 1'b1;
    clear_prev();
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    clear_prev();
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("postrst_busy", busy, 1'b0);
      chk1("postrst_enc_req", enc_req, 1'b0);
      chk1("postrst_mem_req", mem_req, 1'b0);
    end
    run_frame(32'h0000_4000, 64, 2, 1, 100, 100, 1, 3, -1);
    chk32("a3_blk10", gaddr[64], 32'h0000_4020);
    finish_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
